dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder at the far end of the DREQ/DRW request issued by the
//  execute/memory stages of the 5-stage RISC_toy core. Accepts one word request
//  at a time, models a configurable wait-state latency, performs the read/write
//  on an internal word array and returns DACK, read data and a pipeline stall.
// PARAMETERS
//  DEPTH    256  number of 32-bit words; legal byte addresses 0 .. 4*DEPTH-1
//  WAIT_CYC 2    wait states between acceptance and DACK (0..15)
//  AW       8    word-index width, equals clog2(DEPTH)
// PORTS
//  CLK      in   1   clock, all state updates on the rising edge
//  RSTN     in   1   asynchronous active-low reset
//  DREQ     in   1   request valid, held high until DACK
//  DRW      in   1   1 = write, 0 = read; sampled with DREQ
//  DADDR    in   32  byte address; bits [1:0] must be 00
//  DWD      in   32  write data; sampled with DREQ when DRW=1
//  DRD      out  32  read data; valid in the DACK cycle of a read
//  DACK     out  1   one-cycle completion pulse
//  DERR     out  1   one-cycle error pulse, coincident with DACK
//  DSTALL   out  1   high while an accepted request has not yet completed
// BEHAVIOUR
//  Reset: DRD=0, DACK=0, DERR=0, DSTALL=0, FSM=IDLE, wait counter=0.
//   Memory contents are not reset. Reset asserted mid-request aborts it:
//   no write is committed and no DACK is issued.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: DREQ=1 -> latch DRW, DADDR, DWD; counter=WAIT_CYC; DSTALL=1 from the
//     next cycle; go to WAIT if WAIT_CYC>0, else RESP.
//   WAIT: counter decrements each cycle; at counter==1 go to RESP.
//   RESP: DACK=1 for exactly one cycle, DSTALL=0 in the same cycle; go to IDLE.
//  Latency: DREQ sampled at edge N -> DACK high during cycle N+1+WAIT_CYC.
//  Write commits at the RESP edge only, using latched address/data.
//  Read: DRD = mem[DADDR[AW+1:2]] registered into RESP. DRD holds its value
//   until the next read completes. Writes and errors do not change DRD.
//  Errors: DERR=1 with DACK when either condition holds:
//   - DADDR[1:0] != 0 (misaligned);
//   - DADDR >= 4*DEPTH (out of range).
//   On error: no write; for a read, DRD = 32'h0. Error timing equals normal timing.
//  Inputs are ignored outside IDLE. DREQ still high in the cycle after DACK
//   (back-to-back) is accepted as a new request; there are no idle bubbles.
//  Changes to DRW, DADDR or DWD after acceptance have no effect.
//  DSTALL = (state != IDLE) && !(state == RESP). With WAIT_CYC=0, DSTALL stays 0
//   and DACK follows acceptance by one cycle.
//  Address arithmetic is unsigned 32-bit. No byte enables; word access only.
// TESTING
//  1. Reset, then write 0xDEADBEEF @0x10 with WAIT_CYC=2 -> DACK in cycle N+3,
//     DSTALL high during cycles N+1..N+2; a read of 0x10 then returns 0xDEADBEEF.
//  2. Back-to-back: write 0x1234 @0x0, then read 0x0 with DREQ held -> second DACK
//     WAIT_CYC+1 cycles after the first, DRD=0x1234.
//  3. Misaligned read @0x6 -> DACK=1, DERR=1, DRD=0; memory unchanged.
//  4. Out-of-range write @0x400 (DEPTH=256) -> DERR=1, no write; a read of 0x0
//     afterwards is unchanged.
//  5. Pulse RSTN low during WAIT of a write @0x20 -> no DACK, all outputs 0;
//     mem[0x20] keeps its old value.
//  6. WAIT_CYC=0 sweep: 16 random read/write pairs -> each DACK one cycle after
//     acceptance, DSTALL never high, data matches the scoreboard.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Word-access data-memory bus between the core's memory stage and the data-memory responder.
// Handshake: the master raises dreq with drw/daddr/dwd and holds it until it sees dack; the
//   responder samples the request on an edge where dreq=1 in IDLE or RESP (the dack cycle).
//   A master that has nothing further to issue must drop dreq in the dack cycle.
//   dack/derr pulse for one cycle, drd is valid in the dack cycle of a read.
//   dstall is high while an accepted request is still waiting.
interface dmem_responder_if;
   logic        dreq;
   logic        drw;
   logic [31:0] daddr;
   logic [31:0] dwd;
   logic [31:0] drd;
   logic        dack;
   logic        derr;
   logic        dstall;

   modport master (output dreq, drw, daddr, dwd, input drd, dack, derr, dstall);
   modport slave  (input dreq, drw, daddr, dwd, output drd, dack, derr, dstall);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one word request at a time, WAIT_CYC wait states, then a
// one-cycle dack with read data or an error pulse. AW must equal clog2(DEPTH).
module dmem_responder #(
   parameter int DEPTH    = 256,
   parameter int WAIT_CYC = 2,
   parameter int AW       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   dmem_responder_if.slave  bus,
   output logic [1:0]       state_dbg
);

   localparam logic [1:0]  S_IDLE = 2'd0;
   localparam logic [1:0]  S_WAIT = 2'd1;
   localparam logic [1:0]  S_RESP = 2'd2;

   localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH);
   localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYC);
   localparam bit          ZERO_WAIT  = (WAIT_CYC == 0);

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic          wr_q;
   logic          err_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   wd_q;
   logic [31:0]   drd_q;
   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic          go_resp;
   logic          in_err;
   logic [AW-1:0] in_idx;
   logic          cur_wr;
   logic          cur_err;
   logic [AW-1:0] cur_idx;
   logic          fwd;
   logic          mem_we;
   logic [31:0]   rd_word;

   // The request being completed comes straight from the bus when it is accepted and
   // finishes on the same edge (zero wait states), otherwise from the latched copy.
   always_comb begin
      in_err  = (bus.daddr[1:0] != 2'b00) || (bus.daddr >= BYTE_LIMIT);
      in_idx  = bus.daddr[AW+1:2];
      accept  = bus.dreq && ((state == S_IDLE) || (state == S_RESP));
      go_resp = (accept && ZERO_WAIT) || ((state == S_WAIT) && (cnt == 4'd1));
      cur_wr  = accept ? bus.drw : wr_q;
      cur_err = accept ? in_err  : err_q;
      cur_idx = accept ? in_idx  : idx_q;
      mem_we  = (state == S_RESP) && wr_q && !err_q;
      // A read accepted on the edge that commits a write to the same word sees the new data.
      fwd     = mem_we && (idx_q == cur_idx);
      rd_word = 32'h0;
      if (!cur_err) rd_word = fwd ? wd_q : mem[cur_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         wr_q  <= 1'b0;
         err_q <= 1'b0;
         idx_q <= '0;
         wd_q  <= 32'h0;
         drd_q <= 32'h0;
      end else begin
         if (accept) begin
            wr_q  <= bus.drw;
            err_q <= in_err;
            idx_q <= in_idx;
            wd_q  <= bus.dwd;
            cnt   <= WAIT_INIT;
            state <= ZERO_WAIT ? S_RESP : S_WAIT;
         end else begin
            case (state)
               S_WAIT: begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) state <= S_RESP;
               end
               default: state <= S_IDLE;
            endcase
         end
         if (go_resp && !cur_wr) drd_q <= rd_word;
      end
   end

   // Memory is deliberately not reset; a reset during a request reaches IDLE before any commit.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx_q] <= wd_q;
   end

   assign bus.drd    = drd_q;
   assign bus.dack   = (state == S_RESP);
   assign bus.derr   = (state == S_RESP) && err_q;
   assign bus.dstall = (state != S_IDLE) && !(state == S_RESP);
   assign state_dbg  = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYC=2 instance driven from a vector table plus reset
// and back-to-back sequences, and a WAIT_CYC=0 instance swept with random write/read pairs.
module tb_dmem_responder;

   logic clk;
   logic rst_n;
   logic [1:0] state_w2;
   logic [1:0] state_w0;

   dmem_responder_if bus_w2 ();
   dmem_responder_if bus_w0 ();

   dmem_responder #(.DEPTH(256), .WAIT_CYC(2), .AW(8)) u_w2 (
      .clk(clk), .rst_n(rst_n), .bus(bus_w2), .state_dbg(state_w2));
   dmem_responder #(.DEPTH(256), .WAIT_CYC(0), .AW(8)) u_w0 (
      .clk(clk), .rst_n(rst_n), .bus(bus_w0), .state_dbg(state_w0));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        exp_err;
      logic [31:0] exp_drd;
      bit          b2b;
   } vec_t;

   vec_t vecs[13];

   logic [31:0] exp_q[$];
   logic [31:0] model[256];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver tasks; inst 0 = WAIT_CYC=2 instance, inst 1 = WAIT_CYC=0 instance
   task automatic drive(input bit inst, input logic req, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd);
      if (inst == 1'b0) begin
         bus_w2.dreq = req; bus_w2.drw = wr; bus_w2.daddr = addr; bus_w2.dwd = wd;
      end else begin
         bus_w0.dreq = req; bus_w0.drw = wr; bus_w0.daddr = addr; bus_w0.dwd = wd;
      end
   endtask

   task automatic sample(input bit inst, output logic dk, output logic er,
                         output logic st, output logic [31:0] rd);
      if (inst == 1'b0) begin
         dk = bus_w2.dack; er = bus_w2.derr; st = bus_w2.dstall; rd = bus_w2.drd;
      end else begin
         dk = bus_w0.dack; er = bus_w0.derr; st = bus_w0.dstall; rd = bus_w0.drd;
      end
   endtask

   // Called at a negedge; returns at the negedge of the dack cycle (b2b) or one idle cycle later.
   task automatic run_req(input bit inst, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_err,
                          input logic [31:0] exp_drd, input bit b2b, input string name);
      int wc;
      bit done;
      logic dk, er, st;
      logic [31:0] rd;
      wc = (inst == 1'b0) ? 2 : 0;
      done = 1'b0;
      drive(inst, 1'b1, wr, addr, wd);
      for (int k = 1; k <= 20 && !done; k++) begin
         @(negedge clk);
         sample(inst, dk, er, st, rd);
         check({name, " dstall"}, 32'(st), 32'(!dk && (wc > 0)));
         if (dk) begin
            done = 1'b1;
            check({name, " latency"}, 32'(k), 32'(wc + 1));
            check({name, " derr"}, 32'(er), 32'(exp_err));
            check({name, " drd"}, rd, exp_drd);
         end else if (k == 1) begin
            // scramble the bus after acceptance; the latched request must win
            drive(inst, 1'b1, ~wr, ~addr, ~wd);
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: dack=0 after 20 cycles, required 1", name);
      end
      if (!b2b) begin
         drive(inst, 1'b0, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
         sample(inst, dk, er, st, rd);
         check({name, " idle dack"}, 32'(dk), 32'h0);
      end
   endtask

   initial begin
      logic dk, er, st;
      logic [31:0] rd;
      logic [31:0] last_drd;
      logic [31:0] wdata;
      int idx;
      bit pair_b2b;

      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0000, 32'h0000_1234, 1'b0, 32'hDEAD_BEEF, 1'b1};
      vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_1234, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
      vecs[5]  = '{1'b1, 32'h0000_0400, 32'h0000_0BAD, 1'b1, 32'h0000_0000, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_1234, 1'b1};
      vecs[7]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0000_1234, 1'b0};
      vecs[8]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0};
      vecs[9]  = '{1'b0, 32'h0000_03FD, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
      vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
      vecs[11] = '{1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h1111_2222, 1'b0};

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         sample(i[0], dk, er, st, rd);
         check($sformatf("reset%0d dack", i), 32'(dk), 32'h0);
         check($sformatf("reset%0d derr", i), 32'(er), 32'h0);
         check($sformatf("reset%0d dstall", i), 32'(st), 32'h0);
         check($sformatf("reset%0d drd", i), rd, 32'h0);
      end
      check("reset state_w2", 32'(state_w2), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++)
         run_req(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp_err,
                 vecs[i].exp_drd, vecs[i].b2b, $sformatf("vec%0d", i));

      // reset pulse in the WAIT phase of a write to 0x20
      drive(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_5555);
      @(negedge clk);
      check("abort dstall before reset", 32'(bus_w2.dstall), 32'h1);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("abort dack", 32'(bus_w2.dack), 32'h0);
      check("abort derr", 32'(bus_w2.derr), 32'h0);
      check("abort dstall", 32'(bus_w2.dstall), 32'h0);
      check("abort drd", bus_w2.drd, 32'h0);
      check("abort state", 32'(state_w2), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("abort no dack", 32'(bus_w2.dack), 32'h0);
      end
      run_req(1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h1111_2222, 1'b0, "abort readback");

      // zero-wait sweep with a scoreboard
      last_drd = 32'h0;
      for (int p = 0; p < 16; p++) begin
         idx      = $urandom_range(0, 255);
         wdata    = $urandom;
         pair_b2b = ($urandom_range(0, 1) == 1);
         model[idx] = wdata;
         run_req(1'b1, 1'b1, 32'(idx) << 2, wdata, 1'b0, last_drd, 1'b1,
                 $sformatf("sweep%0d wr", p));
         exp_q.push_back(model[idx]);
         last_drd = exp_q.pop_front();
         run_req(1'b1, 1'b0, 32'(idx) << 2, 32'h0, 1'b0, last_drd, pair_b2b,
                 $sformatf("sweep%0d rd", p));
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("sweep final dstall", 32'(bus_w0.dstall), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
